// File: rtl/row_result_collector.sv
// -----------------------------------------------------------------------------
// row_result_collector
//
// Purpose:
//   Sits behind a 3-MAC row element. On each rising edge of the row-done level
//   the three 2*DW accumulators are captured and summed (S1). On the following
//   clock the sum is shifted, optionally ReLU-clamped and saturated to OW bits
//   (S2), then pushed with a tile-last tag into a small FIFO. The FIFO head is
//   presented on a valid/ready stream.
//
// Parameters:
//   DW         input element width (accumulators are 2*DW signed)
//   OW         output result width, signed
//   SHIFT      arithmetic right shift applied to the row sum
//   RELU_EN    1 = negative results become 0 before saturation
//   FIFO_DEPTH result FIFO entries (power of 2, >= 2)
//   ROWS       rows per tile; out_last marks row index ROWS-1
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous reset, active-low
//   acc0_in      in   signed accumulator, MAC 0
//   acc1_in      in   signed accumulator, MAC 1
//   acc2_in      in   signed accumulator, MAC 2
//   row_done_in  in   row done level from the row element
//   out_data     out  signed row result at the FIFO head
//   out_valid    out  out_data/out_last valid
//   out_ready    in   consumer accepts when out_valid & out_ready
//   out_last     out  result is the last row of its tile
//   overflow     out  sticky flag: a result was dropped because the FIFO was full
//   clear_ovf    in   synchronous clear of overflow (a same-cycle drop wins)
//   busy         out  S1 occupied or FIFO non-empty
// -----------------------------------------------------------------------------
module row_result_collector #(
   parameter int DW         = 16,
   parameter int OW         = 16,
   parameter int SHIFT      = 0,
   parameter int RELU_EN    = 1,
   parameter int FIFO_DEPTH = 4,
   parameter int ROWS       = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic signed [2*DW-1:0] acc0_in,
   input  logic signed [2*DW-1:0] acc1_in,
   input  logic signed [2*DW-1:0] acc2_in,
   input  logic                 row_done_in,
   output logic signed [OW-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last,
   output logic                 overflow,
   input  logic                 clear_ovf,
   output logic                 busy
);

   // Sum of three 2*DW values needs two extra bits to be overflow-free.
   localparam int SW = 2*DW + 2;
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

   localparam logic signed [SW-1:0] SAT_MAX = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [SW-1:0] SAT_MIN = {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};
   localparam logic [CW-1:0]        FULL_CNT = CW'(FIFO_DEPTH);
   localparam logic [RW-1:0]        LAST_ROW = RW'(ROWS - 1);

   // ---------------------------------------------------------------------------
   // Result shaping helpers
   // ---------------------------------------------------------------------------
   function automatic logic signed [SW-1:0] relu_fn(input logic signed [SW-1:0] v);
      if ((RELU_EN != 0) && v[SW-1]) begin
         return '0;
      end
      return v;
   endfunction

   function automatic logic signed [OW-1:0] sat_fn(input logic signed [SW-1:0] v);
      if (v > SAT_MAX) begin
         return {1'b0, {(OW-1){1'b1}}};
      end else if (v < SAT_MIN) begin
         return {1'b1, {(OW-1){1'b0}}};
      end
      return v[OW-1:0];
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic                 done_prev_q;
   logic                 s1_vld_q,  s1_vld_d;
   logic signed [SW-1:0] sum_q;
   logic [RW-1:0]        row_cnt_q, row_cnt_d;
   logic [OW:0]          mem_q [FIFO_DEPTH];   // {last, data}
   logic [AW-1:0]        wr_ptr_q,  wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q,  rd_ptr_d;
   logic [CW-1:0]        count_q,   count_d;
   logic                 ovf_q,     ovf_d;

   logic                 capture;
   logic signed [SW-1:0] sum_d;
   logic signed [SW-1:0] shifted;
   logic signed [OW-1:0] result;
   logic                 result_last;
   logic                 fifo_full;
   logic                 pop;
   logic                 push;
   logic                 drop;

   // ---------------------------------------------------------------------------
   // S1: capture on the rising edge of the done level and sum
   // ---------------------------------------------------------------------------
   assign capture = row_done_in & ~done_prev_q;
   assign sum_d   = {{2{acc0_in[2*DW-1]}}, acc0_in}
                  + {{2{acc1_in[2*DW-1]}}, acc1_in}
                  + {{2{acc2_in[2*DW-1]}}, acc2_in};

   always_ff @(posedge clk) begin
      if (capture) begin
         sum_q <= sum_d;
      end
   end

   // ---------------------------------------------------------------------------
   // S2: shift, ReLU, saturate, tag and push
   // ---------------------------------------------------------------------------
   assign shifted     = sum_q >>> SHIFT;
   assign result      = sat_fn(relu_fn(shifted));
   assign result_last = (row_cnt_q == LAST_ROW);

   assign fifo_full = (count_q == FULL_CNT);
   assign out_valid = (count_q != '0);
   assign pop       = out_valid & out_ready;
   // A full FIFO still takes the push when the head leaves in the same cycle.
   assign push      = s1_vld_q & (~fifo_full | pop);
   assign drop      = s1_vld_q & fifo_full & ~pop;

   always_comb begin
      s1_vld_d  = capture;
      row_cnt_d = row_cnt_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      ovf_d     = ovf_q;

      // Row counter advances even for dropped results so tiles stay framed.
      if (s1_vld_q) begin
         row_cnt_d = result_last ? '0 : row_cnt_q + 1'b1;
      end

      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // A drop in the same cycle as a clear leaves the flag set.
      if (drop) begin
         ovf_d = 1'b1;
      end else if (clear_ovf) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done_prev_q <= 1'b0;
         s1_vld_q    <= 1'b0;
         row_cnt_q   <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         ovf_q       <= 1'b0;
      end else begin
         done_prev_q <= row_done_in;
         s1_vld_q    <= s1_vld_d;
         row_cnt_q   <= row_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         ovf_q       <= ovf_d;
      end
   end

   // Storage is cleared on reset so the head reads zero out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push) begin
         mem_q[wr_ptr_q] <= {result_last, result};
      end
   end

   // ---------------------------------------------------------------------------
   // Output stream
   // ---------------------------------------------------------------------------
   assign out_data = mem_q[rd_ptr_q][OW-1:0];
   assign out_last = mem_q[rd_ptr_q][OW];
   assign overflow = ovf_q;
   assign busy     = s1_vld_q | out_valid;

endmodule
